// File: rtl/tx_uart_arbiter_if.sv
// Handshake bundle between the byte producers, the arbiter and the Tx_uart.
// slave  : arbiter side (consumes requests and tx_done, drives load/ack/status)
// master : producer / transmitter side
interface tx_uart_arbiter_if #(
  parameter int NB_BITS = 8,
  parameter int NB_REQ  = 4,
  parameter int NB_ID   = 2
);
  logic [NB_REQ-1:0]         i_req;
  logic [NB_REQ*NB_BITS-1:0] i_data;
  logic [NB_REQ-1:0]         o_ack;
  logic [NB_BITS-1:0]        o_tx_data;
  logic                      o_tx_data_ready;
  logic                      i_tx_done;
  logic                      o_busy;
  logic [NB_ID-1:0]          o_grant_id;

  modport slave (
    input  i_req, i_data, i_tx_done,
    output o_ack, o_tx_data, o_tx_data_ready, o_busy, o_grant_id
  );

  modport master (
    output i_req, i_data, i_tx_done,
    input  o_ack, o_tx_data, o_tx_data_ready, o_busy, o_grant_id
  );
endinterface

// File: rtl/tx_uart_arbiter.sv
// Round-robin arbiter sharing one Tx_uart among NB_REQ byte sources.
// The granted byte is latched at grant, strobed into the transmitter for one
// cycle, and the requester is acked one cycle after the transmitter's done.
// Optional build macro: TX_ARB_TAG_EN -- each grant first sends a tag byte
// {TAG_PREFIX, grant_id} ahead of the data byte.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | no transfer; arbitrate among i_req starting at ptr
//  ST_TLOAD | (tag build) tag byte on o_tx_data, load strobe high
//  ST_TWAIT | (tag build) tag byte in flight, wait for i_tx_done
//  ST_LOAD  | data byte on o_tx_data, load strobe high
//  ST_WAIT  | data byte in flight, wait for i_tx_done
//  ST_ACK   | ack pulse to the granted requester, advance ptr
module tx_uart_arbiter #(
  parameter int NB_BITS = 8,
  parameter int NB_REQ  = 4,
  parameter int NB_ID   = 2
`ifdef TX_ARB_TAG_EN
  , parameter logic [NB_BITS-NB_ID-1:0] TAG_PREFIX = 6'b101000
`endif
) (
  input logic              i_clk,
  input logic              i_rst,
  tx_uart_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ACK   = 3'd3
`ifdef TX_ARB_TAG_EN
    , ST_TLOAD = 3'd4,
    ST_TWAIT = 3'd5
`endif
  } state_t;

  state_t             state, state_nxt;
  logic [NB_ID-1:0]   ptr;
  logic [NB_ID-1:0]   grant_q;
  logic [NB_ID-1:0]   pick_id;
  logic               pick_found;
  logic [NB_REQ-1:0]  req_rot;
  logic [NB_ID:0]     cand;
  logic [NB_BITS-1:0] pick_byte;
  logic [NB_BITS-1:0] tx_data_q;
  logic [NB_REQ-1:0]  ack_q;
  logic               tx_ready_q;
  logic               busy_q;
`ifdef TX_ARB_TAG_EN
  logic [NB_BITS-1:0] data_hold;
`endif

  // Round-robin pick: rotate requests so bit 0 is ptr, lowest set offset wins.
  always_comb begin
    req_rot    = NB_REQ'({bus.i_req, bus.i_req} >> ptr);
    pick_found = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int i = NB_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        pick_found = 1'b1;
        cand       = {1'b0, ptr} + (NB_ID + 1)'(i);
        if (cand >= (NB_ID + 1)'(NB_REQ)) begin
          cand = cand - (NB_ID + 1)'(NB_REQ);
        end
        pick_id = cand[NB_ID-1:0];
      end
    end
  end

  // Byte of the requester about to be granted.
  always_comb begin
    pick_byte = '0;
    for (int k = 0; k < NB_REQ; k++) begin
      if (pick_id == NB_ID'(k)) begin
        pick_byte = bus.i_data[k*NB_BITS +: NB_BITS];
      end
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; done is only honoured in the wait states.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (pick_found) begin
`ifdef TX_ARB_TAG_EN
          state_nxt = ST_TLOAD;
`else
          state_nxt = ST_LOAD;
`endif
        end
      end
`ifdef TX_ARB_TAG_EN
      ST_TLOAD: state_nxt = ST_TWAIT;
      ST_TWAIT: if (bus.i_tx_done) state_nxt = ST_LOAD;
`endif
      ST_LOAD:  state_nxt = ST_WAIT;
      ST_WAIT:  if (bus.i_tx_done) state_nxt = ST_ACK;
      ST_ACK:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Registered outputs decoded from the state being entered, plus grant/ptr.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      tx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      ack_q      <= '0;
      tx_data_q  <= '0;
      grant_q    <= '0;
      ptr        <= '0;
`ifdef TX_ARB_TAG_EN
      data_hold  <= '0;
`endif
    end else begin
`ifdef TX_ARB_TAG_EN
      tx_ready_q <= (state_nxt == ST_LOAD) || (state_nxt == ST_TLOAD);
`else
      tx_ready_q <= (state_nxt == ST_LOAD);
`endif
      busy_q <= (state_nxt != ST_IDLE);
      ack_q  <= (state_nxt == ST_ACK) ? (NB_REQ'(1) << grant_q) : '0;

      if (state == ST_IDLE && pick_found) begin
        grant_q <= pick_id;
`ifdef TX_ARB_TAG_EN
        tx_data_q <= {TAG_PREFIX, pick_id};
        data_hold <= pick_byte;
`else
        tx_data_q <= pick_byte;
`endif
      end

`ifdef TX_ARB_TAG_EN
      // Tag byte finished: swap in the byte captured at grant time.
      if (state == ST_TWAIT && bus.i_tx_done) begin
        tx_data_q <= data_hold;
      end
`endif

      if (state == ST_ACK) begin
        if (grant_q == NB_ID'(NB_REQ - 1)) begin
          ptr <= '0;
        end else begin
          ptr <= grant_q + 1'b1;
        end
      end
    end
  end

  assign bus.o_ack           = ack_q;
  assign bus.o_tx_data       = tx_data_q;
  assign bus.o_tx_data_ready = tx_ready_q;
  assign bus.o_busy          = busy_q;
  assign bus.o_grant_id      = grant_q;

endmodule

// File: tb/tb_tx_uart_arbiter.sv
// Self-checking bench for tx_uart_arbiter. A transaction-level model (queue of
// bytes per grant, round-robin search by modular arithmetic) predicts every
// output each cycle; directed tests pin it with literal expectations.
module tb_tx_uart_arbiter;

`ifdef TX_ARB_TAG_EN
  localparam int NSTR = 2;
`else
  localparam int NSTR = 1;
`endif
  localparam int NB_REQ = 4;

  logic i_clk;
  logic i_rst;
  logic [7:0] src [NB_REQ];

  tx_uart_arbiter_if #(.NB_BITS(8), .NB_REQ(NB_REQ), .NB_ID(2)) bus ();

  tx_uart_arbiter dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus.slave)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always_comb bus.i_data = {src[3], src[2], src[1], src[0]};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         e_busy, e_strobe;
  logic [3:0] e_ack;
  logic [7:0] e_data;
  int         e_grant;
  int         m_ptr, m_k;
  bit         m_was_strobe, m_was_ack;
  logic [7:0] m_q [$];
  logic [7:0] sent_log [$];
  int         ack_log [$];

  always @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      e_busy = 0; e_strobe = 0; e_ack = '0; e_data = '0; e_grant = 0;
      m_ptr = 0; m_q.delete();
    end else begin
      m_was_strobe = e_strobe;
      m_was_ack    = (e_ack != 0);
      e_strobe = 0;
      e_ack    = '0;
      if (m_was_ack) begin
        e_busy = 0;
        m_ptr  = (e_grant + 1) % NB_REQ;
      end else if (!e_busy) begin
        m_k = -1;
        for (int i = 0; i < NB_REQ; i++)
          if (m_k < 0 && ((bus.i_req >> ((m_ptr + i) % NB_REQ)) & 4'b1) != 0)
            m_k = (m_ptr + i) % NB_REQ;
        if (m_k >= 0) begin
          e_grant = m_k;
`ifdef TX_ARB_TAG_EN
          m_q.push_back(8'hA0 + 8'(m_k));
`endif
          m_q.push_back(src[m_k]);
          e_data   = m_q.pop_front();
          e_strobe = 1;
          e_busy   = 1;
          sent_log.push_back(e_data);
        end
      end else if (!m_was_strobe && bus.i_tx_done) begin
        if (m_q.size() > 0) begin
          e_data   = m_q.pop_front();
          e_strobe = 1;
          sent_log.push_back(e_data);
        end else begin
          e_ack = 4'b0001 << e_grant;
          ack_log.push_back(e_grant);
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge i_clk) begin
    check("cyc_busy",   bus.o_busy,          e_busy);
    check("cyc_strobe", bus.o_tx_data_ready, e_strobe);
    check("cyc_ack",    bus.o_ack,           e_ack);
    check("cyc_data",   bus.o_tx_data,       e_data);
    check("cyc_grant",  bus.o_grant_id,      e_grant);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic wait_strobe();
    int n = 0;
    while (!bus.o_tx_data_ready && n < 40) begin tick(1); n++; end
    if (!bus.o_tx_data_ready) check("strobe_timeout", 0, 1);
  endtask

  task automatic wait_ack();
    int n = 0;
    while (bus.o_ack == 0 && n < 40) begin tick(1); n++; end
    if (bus.o_ack == 0) check("ack_timeout", 0, 1);
  endtask

  task automatic pulse_done(input int d);
    tick(d);
    bus.i_tx_done = 1'b1;
    tick(1);
    bus.i_tx_done = 1'b0;
  endtask

  task automatic serve(output logic [7:0] last_byte, output logic [3:0] ack_seen);
    last_byte = '0;
    for (int b = 0; b < NSTR; b++) begin
      wait_strobe();
      last_byte = bus.o_tx_data;
      pulse_done(2);
    end
    wait_ack();
    ack_seen = bus.o_ack;
  endtask

  task automatic do_reset();
    i_rst = 1'b0;
    tick(2);
    i_rst = 1'b1;
  endtask

  logic [7:0] byte_v;
  logic [3:0] ack_v;
  logic [7:0] exp_log [$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b0;
    bus.i_req = '0;
    bus.i_tx_done = 1'b0;
    for (int i = 0; i < NB_REQ; i++) src[i] = 8'h00;
    tick(2);

    // reset values
    check("rst_busy",  bus.o_busy, 0);
    check("rst_ack",   bus.o_ack, 0);
    check("rst_ready", bus.o_tx_data_ready, 0);
    check("rst_data",  bus.o_tx_data, 0);
    check("rst_grant", bus.o_grant_id, 0);
    i_rst = 1'b1;
    tick(1);

    // 1: single requester 2
    src[2] = 8'h53;
    bus.i_req = 4'b0100;
    for (int b = 0; b < NSTR; b++) begin
      wait_strobe();
      if (b == NSTR - 1) begin
        check("t1_data",  bus.o_tx_data, 8'h53);
        check("t1_grant", bus.o_grant_id, 2);
      end
      pulse_done(2);
    end
    wait_ack();
    check("t1_ack", bus.o_ack, 4'b0100);
    bus.i_req = '0;
    tick(1);
    check("t1_ack_len", bus.o_ack, 0);
    check("t1_busy",    bus.o_busy, 0);

    // 2: all four from reset, each dropped on its ack
    do_reset();
    sent_log.delete(); ack_log.delete();
    src[0] = 8'h10; src[1] = 8'h11; src[2] = 8'h12; src[3] = 8'h13;
    bus.i_req = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      serve(byte_v, ack_v);
      check("t2_byte", byte_v, 8'h10 + 8'(r));
      check("t2_ack",  ack_v, 4'b0001 << r);
      bus.i_req = bus.i_req & ~ack_v;
    end
    tick(2);
    exp_log.delete();
    for (int r = 0; r < 4; r++) begin
`ifdef TX_ARB_TAG_EN
      exp_log.push_back(8'hA0 + 8'(r));
`endif
      exp_log.push_back(8'h10 + 8'(r));
    end
    check("t2_log_len", sent_log.size(), exp_log.size());
    for (int i = 0; i < exp_log.size() && i < sent_log.size(); i++)
      check("t2_log_byte", sent_log[i], exp_log[i]);
    check("t2_acklog_len", ack_log.size(), 4);
    for (int i = 0; i < ack_log.size() && i < 4; i++)
      check("t2_acklog_id", ack_log[i], i);

    // 3: 0 and 3 held continuously -> alternate
    bus.i_req = 4'b1001;
    for (int r = 0; r < 4; r++) begin
      serve(byte_v, ack_v);
      check("t3_ack", ack_v, (r % 2 == 0) ? 4'b0001 : 4'b1000);
    end
    bus.i_req = '0;
    tick(2);

    // 4: done in IDLE ignored, done in the load cycle ignored
    bus.i_tx_done = 1'b1;
    tick(1);
    bus.i_tx_done = 1'b0;
    tick(2);
    check("t4_idle_busy", bus.o_busy, 0);
    check("t4_idle_ack",  bus.o_ack, 0);
    src[2] = 8'h5A;
    bus.i_req = 4'b0100;
    wait_strobe();
    bus.i_tx_done = 1'b1;
    tick(1);
    bus.i_tx_done = 1'b0;
    check("t4_load_busy",  bus.o_busy, 1);
    check("t4_load_ack",   bus.o_ack, 0);
    check("t4_load_ready", bus.o_tx_data_ready, 0);
    pulse_done(1);
    for (int b = 1; b < NSTR; b++) begin
      wait_strobe();
      pulse_done(2);
    end
    wait_ack();
    check("t4_ack", bus.o_ack, 4'b0100);
    bus.i_req = '0;
    tick(2);

    // 5: async reset mid-transfer; ptr (now 3) must return to 0
    src[3] = 8'h33;
    bus.i_req = 4'b1000;
    wait_strobe();
    tick(1);
    #2;
    i_rst = 1'b0;
    #1;
    check("t5_busy",  bus.o_busy, 0);
    check("t5_ready", bus.o_tx_data_ready, 0);
    check("t5_ack",   bus.o_ack, 0);
    check("t5_data",  bus.o_tx_data, 0);
    check("t5_grant", bus.o_grant_id, 0);
    tick(2);
    src[1] = 8'h77;
    bus.i_req = 4'b1010;
    i_rst = 1'b1;
    wait_strobe();
    check("t5_regrant", bus.o_grant_id, 1);
    for (int b = 0; b < NSTR; b++) begin
      if (b > 0) wait_strobe();
      byte_v = bus.o_tx_data;
      pulse_done(2);
    end
    check("t5_byte", byte_v, 8'h77);
    wait_ack();
    check("t5_ack2", bus.o_ack, 4'b0010);
    bus.i_req = '0;
    tick(2);

`ifdef TX_ARB_TAG_EN
    // 6: tag byte precedes data, single ack
    do_reset();
    src[1] = 8'h53;
    bus.i_req = 4'b0010;
    wait_strobe();
    check("t6_tag", bus.o_tx_data, 8'hA1);
    pulse_done(2);
    check("t6_no_early_ack", bus.o_ack, 0);
    wait_strobe();
    check("t6_data", bus.o_tx_data, 8'h53);
    pulse_done(2);
    wait_ack();
    check("t6_ack", bus.o_ack, 4'b0010);
    bus.i_req = '0;
    tick(2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
